// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the core (master) and a data-memory responder (slave).
// Carries the request channel (addr/wdata/rw/size/sign) and the response channel (rdata/err).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_rw;
   logic [1:0]  req_size;
   logic        req_sign;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_addr, req_wdata, req_rw, req_size, req_sign, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, req_wdata, req_rw, req_size, req_sign, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers after LATENCY cycles.
// Ports: clock, reset (async, active-low), bus (dmem_responder_if.slave: req/rsp channels).
// Optional DMEM_ACCESS_ERR_EN: flags misaligned/out-of-range accesses on rsp_err.
module dmem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2
) (
   input  logic             clock,
   input  logic             reset,
   dmem_responder_if.slave  bus
);
   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;

   logic          ready_q;
   logic          valid_q;
   logic          err_q;
   logic [31:0]   rdata_q;

   logic [31:0]   a_addr;
   logic [31:0]   a_wdata;
   logic          a_rw;
   logic          a_sign;
   logic [1:0]    a_size;

   logic [31:0]   mem [DEPTH_WORDS];

   logic          accept;
   logic          fire;
   logic          done;

   logic [31:0]   word_off;
   logic [IW-1:0] idx;
   logic          in_range;
   logic          is_byte;
   logic          is_half;
   logic          acc_err;
   logic          ok;
   logic [31:0]   cur;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic [31:0]   rd_ext;
   logic [31:0]   rd_val;
   logic [3:0]    be;
   logic [31:0]   wd;
   logic [31:0]   merged;
   logic          commit;

   assign accept = (state == IDLE) && ready_q && bus.req_valid;
   assign fire   = (state == WAIT) && (cnt == '0);
   assign done   = (state == RESP) && bus.rsp_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Access decode on the captured request.
   always_comb begin
      word_off = (a_addr - BASE_ADDR) >> 2;
      in_range = (a_addr >= BASE_ADDR) && (word_off < 32'(DEPTH_WORDS));
      idx      = word_off[IW-1:0];
      is_byte  = (a_size == 2'b00);
      is_half  = (a_size == 2'b01);
`ifdef DMEM_ACCESS_ERR_EN
      acc_err  = !in_range
               || (is_half && a_addr[0])
               || (!is_byte && !is_half && (a_addr[1:0] != 2'b00));
`else
      acc_err  = 1'b0;
`endif
      ok       = in_range && !acc_err;
      cur      = mem[idx];
      // Byte uses the full lane; half/word drop the low bits (forced alignment).
      byte_v   = cur[{a_addr[1:0], 3'b000} +: 8];
      half_v   = a_addr[1] ? cur[31:16] : cur[15:0];
      rd_ext   = cur;
      be       = 4'b1111;
      wd       = a_wdata;
      unique case (1'b1)
         is_byte: begin
            rd_ext = {{24{a_sign & byte_v[7]}}, byte_v};
            be     = 4'b0001 << a_addr[1:0];
            wd     = {4{a_wdata[7:0]}};
         end
         is_half: begin
            rd_ext = {{16{a_sign & half_v[15]}}, half_v};
            be     = a_addr[1] ? 4'b1100 : 4'b0011;
            wd     = {2{a_wdata[15:0]}};
         end
         default: begin
            rd_ext = cur;
            be     = 4'b1111;
            wd     = a_wdata;
         end
      endcase
      rd_val = (ok && !a_rw) ? rd_ext : 32'h0;
      for (int i = 0; i < 4; i++)
         merged[8*i +: 8] = be[i] ? wd[8*i +: 8] : cur[8*i +: 8];
      commit = fire && a_rw && ok;
   end

   always_ff @(posedge clock) begin
      if (commit) mem[idx] <= merged;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
         cnt     <= '0;
         a_addr  <= 32'h0;
         a_wdata <= 32'h0;
         a_rw    <= 1'b0;
         a_size  <= 2'b00;
         a_sign  <= 1'b0;
      end else begin
         // Ready comes up on the first IDLE edge (after reset or after a response).
         if (state == IDLE) ready_q <= !accept;
         if (accept) begin
            a_addr  <= bus.req_addr;
            a_wdata <= bus.req_wdata;
            a_rw    <= bus.req_rw;
            a_size  <= bus.req_size;
            a_sign  <= bus.req_sign;
            cnt     <= CNT_LOAD;
         end
         if ((state == WAIT) && (cnt != '0)) cnt <= cnt - 1'b1;
         if (fire) begin
            valid_q <= 1'b1;
            rdata_q <= rd_val;
            err_q   <= acc_err;
         end
         if (done) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
         end
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
endmodule
